// File: rtl/reg_load_arbiter.sv
// -----------------------------------------------------------------------------
// reg_load_arbiter
//   Round-robin arbiter sharing one W-bit loadable register (data R, load
//   strobe L) between NREQ requesters. A grant produces a single-cycle L pulse
//   and a one-hot ack. After the pulse, loads are held off for HOLD_CYC cycles
//   so the downstream register output stays stable.
//
// Ports
//   clk       in   1            system clock, all logic on posedge
//   rst       in   1            synchronous reset, active-high
//   req       in   NREQ         req[i]=1: requester i wants to load
//   req_data  in   NREQ*W       requester i data at [i*W +: W]
//   ack       out  NREQ         one-hot, single-cycle grant acknowledge
//   grant_id  out  clog2(NREQ)  index of last granted requester
//   R         out  W            data to the register R input
//   L         out  1            load strobe to the register L input
//   busy      out  1            high whenever the FSM is not in IDLE
//
// All outputs are registered.
// -----------------------------------------------------------------------------
module reg_load_arbiter #(
  parameter int NREQ     = 4,
  parameter int W        = 3,
  parameter int HOLD_CYC = 2,
  localparam int PW      = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic [PW-1:0]     grant_id,
  output logic [W-1:0]      R,
  output logic              L,
  output logic              busy
);

  // Hold counter is loaded with HOLD_CYC-1 and counts down to zero, so HOLD
  // lasts exactly HOLD_CYC cycles (HOLD_CYC is at most 15).
  localparam logic [3:0] HOLD_INIT = 4'(HOLD_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t            r_state;
  logic [W-1:0]      r_R;
  logic              r_L;
  logic [NREQ-1:0]   r_ack;
  logic [PW-1:0]     r_gid;
  logic [PW-1:0]     r_ptr;
  logic [3:0]        r_cnt;
  logic              r_busy;

  state_t            w_state_next;
  logic [W-1:0]      w_R_next;
  logic              w_L_next;
  logic [NREQ-1:0]   w_ack_next;
  logic [PW-1:0]     w_gid_next;
  logic [PW-1:0]     w_ptr_next;
  logic [3:0]        w_cnt_next;

  logic              w_found;
  logic [PW-1:0]     w_winner;
  int                w_idx;

  // Per-requester data slices.
  logic [W-1:0]      w_data [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign w_data[gi] = req_data[gi*W +: W];
  end

  // Rotating-priority search: offset 0 from ptr has the highest priority.
  // Scanning from the far end and overwriting leaves the nearest requester.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_ptr) + k) % NREQ;
      if (req[w_idx]) begin
        w_found  = 1'b1;
        w_winner = PW'(w_idx);
      end
    end
  end

  // State and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_R     <= '0;
      r_L     <= 1'b0;
      r_ack   <= '0;
      r_gid   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_R     <= w_R_next;
      r_L     <= w_L_next;
      r_ack   <= w_ack_next;
      r_gid   <= w_gid_next;
      r_ptr   <= w_ptr_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // Next-state and next-output logic. L and ack default low so they are
  // only ever high for the single LOAD cycle.
  always_comb begin
    w_state_next = r_state;
    w_R_next     = r_R;
    w_L_next     = 1'b0;
    w_ack_next   = '0;
    w_gid_next   = r_gid;
    w_ptr_next   = r_ptr;
    w_cnt_next   = r_cnt;

    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_R_next     = w_data[w_winner];
          w_L_next     = 1'b1;
          w_ack_next   = {{(NREQ-1){1'b0}}, 1'b1} << w_winner;
          w_gid_next   = w_winner;
          w_ptr_next   = PW'((int'(w_winner) + 1) % NREQ);
          w_state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        w_cnt_next   = HOLD_INIT;
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (r_cnt == '0) begin
          w_state_next = S_IDLE;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign R        = r_R;
  assign L        = r_L;
  assign ack      = r_ack;
  assign grant_id = r_gid;
  assign busy     = r_busy;

endmodule
